// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit.
// Op encodings are also imported by the decoder that drives op.
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    logic        ok;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic is_md(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  // Full-width product or quotient/remainder for one md op.
  // ok=0 marks a divide by zero: the commit must leave hi/lo alone.
  function automatic md_res_t md_compute(
    input md_op_t      op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    md_res_t            r;
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic        [31:0] d;
    logic               ovf;
    r   = '0;
    sp  = '0;
    up  = '0;
    d   = (b == 32'd0) ? 32'd1 : b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    unique case (op)
      MD_MULT: begin
        sp   = $signed({{32{a[31]}}, a}) *
               $signed({{32{b[31]}}, b});
        r.hi = sp[63:32];
        r.lo = sp[31:0];
        r.ok = 1'b1;
      end
      MD_MULTU: begin
        up   = {32'd0, a} * {32'd0, b};
        r.hi = up[63:32];
        r.lo = up[31:0];
        r.ok = 1'b1;
      end
      MD_DIV: begin
        // -2^31 / -1 overflows 32 bits; its result is fixed.
        if (ovf) begin
          r.lo = 32'h8000_0000;
          r.hi = 32'd0;
        end else begin
          r.lo = $signed(a) / $signed(d);
          r.hi = $signed(a) % $signed(d);
        end
        r.ok = (b != 32'd0);
      end
      MD_DIVU: begin
        r.lo = a / d;
        r.hi = a % d;
        r.ok = (b != 32'd0);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multi-cycle multiply/divide unit.
// Owns HI/LO; busy stalls md-class issue until commit.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_t      op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] CNT_MUL = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_DIV = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  md_state_t     state;
  logic [CW-1:0] cnt;
  logic [31:0]   p_hi;
  logic [31:0]   p_lo;
  logic          p_ok;

  md_res_t       res;
  logic [CW-1:0] n_load;
  logic          last;
  logic          open;

  // Result of the op on the issue bus, latched only on accept.
  always_comb begin
    res    = md_compute(op, A, B);
    n_load = is_mul(op) ? CNT_MUL : CNT_DIV;
  end

  // Issue is open when idle or on the commit edge itself.
  always_comb begin
    last = (state == S_BUSY) && (cnt == CNT_ONE);
    open = (state == S_IDLE) || last;
  end

  // Two-state FSM: count down, commit pending result, accept issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_ok  <= 1'b0;
    end else begin
      if (state == S_BUSY) begin
        if (last) begin
          if (p_ok) begin
            hi <= p_hi;
            lo <= p_lo;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CNT_ONE;
        end
      end
      // Later program order wins over the commit above.
      if (open && start) begin
        unique case (op)
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            p_hi  <= res.hi;
            p_lo  <= res.lo;
            p_ok  <= res.ok;
            cnt   <= n_load;
            state <= S_BUSY;
            busy  <= 1'b1;
          end
          MD_MTHI: hi <= A;
          MD_MTLO: lo <= A;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit.
// Directed plan cases followed by random ops against a model.
module tb_md_unit;
  import md_defs::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  md_op_t      op    = MD_NONE;
  logic [31:0] A     = '0;
  logic [31:0] B     = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] ehi  = '0;
  logic [31:0] elo  = '0;

  always #5 clk = ~clk;

  md_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  // Architectural result from plain 64-bit arithmetic.
  function automatic bit ref_md(input md_op_t o,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] h,
                                output logic [31:0] l);
    longint          x, y, q, r;
    longint unsigned ux, uy, p;
    h = '0;
    l = '0;
    x = longint'($signed(a));
    y = longint'($signed(b));
    ux = {32'd0, a};
    uy = {32'd0, b};
    case (o)
      MD_MULT: begin
        q = x * y;
        h = q[63:32];
        l = q[31:0];
        return 1'b1;
      end
      MD_MULTU: begin
        p = ux * uy;
        h = p[63:32];
        l = p[31:0];
        return 1'b1;
      end
      MD_DIV: begin
        if (b == 32'd0) return 1'b0;
        q = x / y;
        r = x - q * y;
        l = q[31:0];
        h = r[31:0];
        return 1'b1;
      end
      MD_DIVU: begin
        if (b == 32'd0) return 1'b0;
        p = ux / uy;
        l = p[31:0];
        p = ux % uy;
        h = p[31:0];
        return 1'b1;
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_all(input string tag, input logic eb);
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  // Issue one mult/div and follow it to commit.
  task automatic do_md(input md_op_t o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input bit noise);
    logic [31:0] nh, nl;
    bit          ok;
    int          n;
    n  = (o == MD_MULT || o == MD_MULTU) ? MC : DC;
    ok = ref_md(o, a, b, nh, nl);
    op = o; A = a; B = b; start = 1'b1;
    tick;
    start = 1'b0; op = MD_NONE;
    for (int k = 0; k < n; k++) begin
      check_all("hold", 1'b1);
      A = $urandom; B = $urandom;
      if (noise && k < n - 1 && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        op = md_op_t'($urandom_range(1, 6));
      end
      tick;
      start = 1'b0; op = MD_NONE;
    end
    if (ok) begin
      ehi = nh;
      elo = nl;
    end
    check_all("commit", 1'b0);
  endtask

  task automatic do_mt(input md_op_t o, input logic [31:0] a);
    op = o; A = a; start = 1'b1;
    tick;
    start = 1'b0; op = MD_NONE;
    if (o == MD_MTHI) ehi = a;
    else elo = a;
    check_all("mt", 1'b0);
  endtask

  initial begin
    md_op_t      ro;
    logic [31:0] ra, rb;

    tick;
    tick;
    check_all("reset", 1'b0);
    reset = 1'b1;
    tick;

    do_md(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    do_md(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    do_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    do_md(MD_DIVU, 32'd7, 32'd2, 1'b0);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    do_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    do_mt(MD_MTHI, 32'h0000_1234);
    do_mt(MD_MTLO, 32'h0000_5678);
    do_md(MD_DIVU, 32'd99, 32'd0, 1'b0);
    chk("dz_hi", hi, 32'h0000_1234);
    chk("dz_lo", lo, 32'h0000_5678);
    do_md(MD_DIV, 32'hFFFF_0000, 32'd0, 1'b0);
    chk("dzs_hi", hi, 32'h0000_1234);
    chk("dzs_lo", lo, 32'h0000_5678);

    do_mt(MD_MTHI, 32'hDEAD_BEEF);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);

    // MTLO and a second MULT during busy must be ignored.
    op = MD_MULT; A = 32'd6; B = 32'd7; start = 1'b1;
    tick;
    op = MD_MTLO; A = 32'd5;
    tick;
    check_all("ign_mtlo", 1'b1);
    op = MD_MULT; A = 32'd100; B = 32'd100;
    tick;
    start = 1'b0; op = MD_NONE;
    check_all("ign_mult", 1'b1);
    for (int k = 0; k < MC - 2; k++) tick;
    ehi = 32'd0;
    elo = 32'd42;
    check_all("ign_done", 1'b0);

    // Reset in the third busy cycle of a DIV.
    op = MD_DIV; A = 32'd100; B = 32'd3; start = 1'b1;
    tick;
    start = 1'b0; op = MD_NONE;
    tick;
    tick;
    #2 reset = 1'b0;
    #1;
    ehi = '0;
    elo = '0;
    check_all("rst_mid", 1'b0);
    tick;
    reset = 1'b1;
    for (int k = 0; k < DC + 2; k++) begin
      tick;
      check_all("rst_after", 1'b0);
    end

    // MULT 3x4, then DIVU 100/7 taken on the commit edge.
    op = MD_MULT; A = 32'd3; B = 32'd4; start = 1'b1;
    tick;
    start = 1'b0; op = MD_NONE;
    for (int k = 0; k < MC - 1; k++) tick;
    op = MD_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
    tick;
    start = 1'b0; op = MD_NONE;
    ehi = 32'd0;
    elo = 32'd12;
    check_all("b2b_first", 1'b1);
    for (int k = 0; k < DC; k++) begin
      check_all("b2b_wait", 1'b1);
      tick;
    end
    ehi = 32'd2;
    elo = 32'd14;
    check_all("b2b_second", 1'b0);

    // Random ops, with ignored issue noise during busy.
    for (int i = 0; i < 40; i++) begin
      ro = md_op_t'($urandom_range(1, 6));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = 32'($urandom_range(0, 300));
        rb = 32'($urandom_range(0, 20));
      end
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      if (ro == MD_MTHI || ro == MD_MTLO) do_mt(ro, ra);
      else do_md(ro, ra, rb, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the EX stage of the five-stage MIPS pipeline. It takes the same forwarded operands the ALU does and owns the architectural HI/LO register pair. It executes mult/multu/div/divu over a fixed number of busy cycles and handles mthi/mtlo in one cycle. It also raises `busy` so the hazard unit can stall md-class instructions until the result is committed.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

Ports:
- `clk`  in  1  pipeline clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe for the EX-stage md instruction, sampled on `clk`.
- `op`  in  3  operation code: `MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`.
- `A`  in  32  rs operand after forwarding.
- `B`  in  32  rt operand after forwarding.
- `busy`  out  1  operation in flight.
- `hi`  out  32  architectural HI register, read by mfhi.
- `lo`  out  32  architectural LO register, read by mflo.

## Operation
- Reset (`reset`=0, any time, asynchronous): `busy`=0, `hi`=0, `lo`=0, counter=0, FSM→IDLE. An in-flight result is discarded.
- FSM states:
  - IDLE:
    - `start`=1 and op ∈ {MULT, MULTU, DIV, DIVU}: latch the computed result into pending registers `p_hi`/`p_lo`, load counter with the op's cycle count, go to BUSY.
    - `start`=1 and op=MTHI: `hi`←A, stay IDLE.
    - `start`=1 and op=MTLO: `lo`←A, stay IDLE.
    - op=MD_NONE, or `start`=0: no action.
  - BUSY: decrement counter each cycle. When counter reaches 1: `hi`←`p_hi`, `lo`←`p_lo`, go to IDLE.
  - BUSY: `start` is ignored regardless of op, including MTHI/MTLO. The hazard unit guarantees no md issue while busy; the bench still checks the ignore behaviour.
- Arithmetic:
  - MULT: signed 32×32→64; `hi`=[63:32], `lo`=[31:0].
  - MULTU: unsigned 32×32→64; same split.
  - DIV: signed; quotient truncates toward zero; `lo`=quotient, `hi`=remainder with the dividend's sign.
  - DIV with A=0x8000_0000 and B=0xFFFF_FFFF: `lo`=0x8000_0000, `hi`=0.
  - DIVU: unsigned; `lo`=A/B, `hi`=A%B.
  - Divide by zero (B=0, DIV or DIVU): full busy period runs, `hi`/`lo` left unchanged.
- `hi`/`lo` always show committed values. Pending results are never visible early.

## Timing
- Start on edge t: `busy`=1 from t for exactly N cycles. N=`MULT_CYCLES` or `DIV_CYCLES`.
- The new `hi`/`lo` values and `busy`=0 both appear after edge t+N. A new `start` is accepted at edge t+N.
- MTHI/MTLO: register updates at the accepting edge. `busy` never asserts.
- Reset asserted mid-BUSY: outputs go to their reset values immediately. After deassertion the FSM is IDLE.
- Operands are sampled only at the accepting edge. A/B changes during BUSY have no effect.

## Structure
- Shared package `md_defs`:
  - `md_op_t` enum with 3-bit encodings `MD_NONE`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4, `MD_MTHI`=5, `MD_MTLO`=6.
  - Default cycle constants.
  - The decoder that drives `op` imports the same package.
- No sub-module:
  - One two-state FSM plus counter.
  - Combinational multiply/divide feeding the pending registers.
  - A separate `md_div_core` is introduced only if timing forces an iterative divider.

## Test plan
- MULT A=0xFFFF_FFFF, B=2 → `busy` high 5 cycles, then `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFFE. MULTU with the same operands → `hi`=1, `lo`=0xFFFF_FFFE.
- DIV A=0xFFFF_FFF9 (−7), B=2 → after 10 cycles `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF. DIVU A=7, B=2 → `lo`=3, `hi`=1.
- DIV A=0x8000_0000, B=0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0. DIVU B=0 with prior `hi`=0x1234, `lo`=0x5678 → `busy` 10 cycles, both unchanged.
- MTHI A=0xDEAD_BEEF → `hi`=0xDEAD_BEEF next cycle, `busy` stays 0. A MULT start, then MTLO A=5 and a second MULT issued during BUSY → both ignored; `lo` equals the first MULT's result.
- Assert `reset` low at cycle 3 of a DIV → `busy`, `hi`, `lo` go to 0 at once. After release, no commit occurs.
- Back-to-back: MULT 3×4 then DIVU 100/7 issued on the cycle `busy` falls → `lo`=12, then `lo`=14, `hi`=2.
